// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// PROGRAM_LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package program_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned LEN_W          = LEN_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK  = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [BYTE_W-1:0]     RX_DATA;
    logic                  RX_VALID;
    logic                  RX_READY;
    logic [ADDR_WIDTH-1:0] ADDR_W;
    logic [DATA_WIDTH-1:0] Q_W;
    logic                  ENABLE_W;

    // Byte source and memory sink side.
    modport master (
        output RX_DATA, RX_VALID,
        input  RX_READY, ADDR_W, Q_W, ENABLE_W
    );

    // Loader side.
    modport slave (
        input  RX_DATA, RX_VALID,
        output RX_READY, ADDR_W, Q_W, ENABLE_W
    );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs accepted bytes little-endian into words; word_valid pulses one
// cycle after the last byte of each word is accepted.
module program_loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              valid,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned SR_W  = WORD_W - BYTE_W;

    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  sr;

    // Earlier bytes shift down so the first byte lands in the low lane.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt        <= '0;
            sr         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (valid) begin
                cnt <= cnt + CNT_W'(1);
                sr  <= {rx_byte, sr[SR_W-1:BYTE_W]};
                if (cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
                    word       <= {rx_byte, sr};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> consecutive memory words.
// PROGRAM_LOADER_CHECKSUM_EN appends an XOR checksum byte to each frame.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    program_loader_if.slave   bus,
    output logic              CORE_RESET,
    output logic              DONE,
    output logic              ERROR,
    output logic [ADDR_WIDTH:0] WORDS_LOADED
);

    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
    localparam int unsigned BCNT_W    = ADDR_WIDTH + 3;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH != WORD_W) begin : g_bad_width
        $error("program_loader: DATA_WIDTH must be 32");
    end

    state_e              state, state_n;
    logic                fire_c, asm_valid_c, rearm_c, data_open_c;
    logic [BYTE_W-1:0]   len_lo;
    logic [LEN_W-1:0]    len_c;
    logic [CNT_W-1:0]    len;
    logic [BCNT_W-1:0]   rx_bytes, total_bytes_c;
    logic [WORD_W-1:0]   word;
    logic                word_valid;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum;
    logic                last_byte_c;
`else
    logic                last_word_c;
`endif

    assign bus.RX_READY  = !RESET && (state != S_DONE) && (state != S_ERR);
    assign fire_c        = bus.RX_VALID && bus.RX_READY;
    assign len_c         = {bus.RX_DATA, len_lo};
    assign total_bytes_c = {len, 2'b00};
    assign data_open_c   = (rx_bytes != total_bytes_c);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign last_byte_c   = ((rx_bytes + BCNT_W'(1)) == total_bytes_c);
`else
    assign last_word_c   = ((WORDS_LOADED + CNT_W'(1)) == len);
`endif

    program_loader_byte_assembler u_asm (
        .clk        (CLK),
        .clear      (RESET || rearm_c),
        .rx_byte    (bus.RX_DATA),
        .valid      (asm_valid_c),
        .word       (word),
        .word_valid (word_valid)
    );

    assign bus.Q_W      = DATA_WIDTH'(word);
    assign bus.ENABLE_W = word_valid;

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_LEN_LO;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        asm_valid_c = 1'b0;
        rearm_c     = 1'b0;
        case (state)
            S_LEN_LO: if (fire_c) state_n = S_LEN_HI;
            S_LEN_HI: begin
                if (fire_c) begin
                    if (32'(len_c) > MAX_WORDS) begin
                        state_n = S_ERR;
                    end else if (len_c == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_n = S_CHECK;
`else
                        state_n = S_DONE;
`endif
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Bytes beyond the announced image are consumed and dropped.
                if (fire_c && data_open_c) asm_valid_c = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (asm_valid_c && last_byte_c) state_n = S_CHECK;
`else
                if (bus.ENABLE_W && last_word_c) state_n = S_DONE;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: if (fire_c) state_n = (bus.RX_DATA == csum) ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: begin
                if (START) begin
                    state_n = S_LEN_LO;
                    rearm_c = 1'b1;
                end
            end
            default: state_n = S_LEN_LO;
        endcase
    end

    // Header capture, counters and status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            len_lo       <= '0;
            len          <= '0;
            rx_bytes     <= '0;
            bus.ADDR_W   <= '0;
            WORDS_LOADED <= '0;
            DONE         <= 1'b0;
            ERROR        <= 1'b0;
            CORE_RESET   <= 1'b1;
        end else begin
            DONE       <= (state_n == S_DONE);
            ERROR      <= (state_n == S_ERR);
            CORE_RESET <= (state_n != S_DONE);
            if (fire_c && state == S_LEN_LO) len_lo <= bus.RX_DATA;
            if (fire_c && state == S_LEN_HI) len <= CNT_W'(len_c);
            if (rearm_c) begin
                rx_bytes     <= '0;
                bus.ADDR_W   <= '0;
                WORDS_LOADED <= '0;
            end else begin
                if (asm_valid_c) rx_bytes <= rx_bytes + BCNT_W'(1);
                if (bus.ENABLE_W) begin
                    WORDS_LOADED <= WORDS_LOADED + CNT_W'(1);
                    // Holds at the top address after a full-size image.
                    if (bus.ADDR_W != '1) bus.ADDR_W <= bus.ADDR_W + ADDR_WIDTH'(1);
                end
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RESET || rearm_c)  csum <= '0;
        else if (asm_valid_c)  csum <= csum ^ bus.RX_DATA;
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as frames
// are driven and checked against every ENABLE_W strobe.
module tb_program_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          core_reset, done, error;
    logic [AW:0]   words_loaded;
    int            vectors = 0;
    int            miscompares = 0;
    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [31:0]   basic_words[$];
    logic [31:0]   one_word[$];
    logic [31:0]   no_words[$];

    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .START        (start),
        .bus          (bus),
        .CORE_RESET   (core_reset),
        .DONE         (done),
        .ERROR        (error),
        .WORDS_LOADED (words_loaded)
    );

    always #5 clk = ~clk;

    // Every write strobe must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (bus.ENABLE_W === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write got addr=%0h data=%08h, none expected", bus.ADDR_W, bus.Q_W);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.ADDR_W, bus.Q_W} !== mon_e) begin
                    miscompares++;
                    $display("FAIL mem_write got addr=%0h data=%08h exp addr=%0h data=%08h",
                             bus.ADDR_W, bus.Q_W, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.RX_VALID = 1'b0;
            vectors++;
            if (bus.RX_READY !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_ready got=%b exp=1", bus.RX_READY);
            end
        end
        @(negedge clk);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        n = 0;
        while (bus.RX_READY !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept timeout got ready=%b exp=1", bus.RX_READY);
            bus.RX_VALID = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_rx();
        @(negedge clk);
        bus.RX_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] words[$], input int gap, input bit bad_ck);
        logic [7:0]  ck;
        logic [7:0]  b;
        logic [15:0] n;
        ck = 8'h00;
        n  = 16'(words.size());
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b  = words[i][8*k +: 8];
                ck = ck ^ b;
                if (k == 3) exp_q.push_back({AW'(i), words[i]});
                send_byte(b, gap);
            end
        end
        if (CK_EN) send_byte(ck ^ {7'd0, bad_ck}, gap);
        idle_rx();
    endtask

    task automatic wait_final();
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL final_state timeout got done=%b error=%b", done, error);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.RX_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got=%b exp=0", bus.RX_READY);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.ADDR_W, bus.Q_W, bus.ENABLE_W, words_loaded} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got addr=%0h q=%08h en=%b words=%0d exp all 0",
                     bus.ADDR_W, bus.Q_W, bus.ENABLE_W, words_loaded);
        end
        vectors++;
        if ({done, error, core_reset, bus.RX_READY} !== 4'b0011) begin
            miscompares++;
            $display("FAIL reset_status got done/err/core_rst/ready=%b exp=0011",
                     {done, error, core_reset, bus.RX_READY});
        end
    endtask

    task automatic test_basic_frame();
        send_frame(basic_words, 0, 1'b0);
        wait_final();
        vectors++;
        if ({done, error, core_reset} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_status got done/err/core_rst=%b exp=100", {done, error, core_reset});
        end
        vectors++;
        if (words_loaded !== 11'd2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_words got=%0d pending=%0d exp=2 pending=0", words_loaded, exp_q.size());
        end
        // A byte offered in DONE must be refused.
        @(negedge clk);
        bus.RX_DATA  = 8'hAA;
        bus.RX_VALID = 1'b1;
        vectors++;
        if (bus.RX_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL done_refuse got ready=%b exp=0", bus.RX_READY);
        end
        idle_rx();
        vectors++;
        if (words_loaded !== 11'd2) begin
            miscompares++;
            $display("FAIL done_hold got words=%0d exp=2", words_loaded);
        end
    endtask

    task automatic test_reload_zero();
        pulse_start();
        vectors++;
        if ({done, error, core_reset, bus.RX_READY} !== 4'b0011) begin
            miscompares++;
            $display("FAIL rearm_status got done/err/core_rst/ready=%b exp=0011",
                     {done, error, core_reset, bus.RX_READY});
        end
        vectors++;
        if (words_loaded !== '0 || bus.ADDR_W !== '0) begin
            miscompares++;
            $display("FAIL rearm_counters got words=%0d addr=%0h exp 0 0", words_loaded, bus.ADDR_W);
        end
        send_frame(no_words, 0, 1'b0);
        wait_final();
        vectors++;
        if ({done, error, core_reset} !== 3'b100 || words_loaded !== '0) begin
            miscompares++;
            $display("FAIL zero_len got done/err/core_rst=%b words=%0d exp=100 words=0",
                     {done, error, core_reset}, words_loaded);
        end
    endtask

    task automatic test_gaps();
        pulse_start();
        send_frame(basic_words, 3, 1'b0);
        wait_final();
        vectors++;
        if ({done, error, core_reset} !== 3'b100 || words_loaded !== 11'd2) begin
            miscompares++;
            $display("FAIL gaps_final got done/err/core_rst=%b words=%0d exp=100 words=2",
                     {done, error, core_reset}, words_loaded);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL gaps_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_full_image();
        logic [31:0] img[$];
        pulse_start();
        for (int i = 0; i < 1024; i++) img.push_back($urandom);
        send_frame(img, 0, 1'b0);
        wait_final();
        vectors++;
        if ({done, error, core_reset} !== 3'b100 || words_loaded !== 11'd1024) begin
            miscompares++;
            $display("FAIL full_image got done/err/core_rst=%b words=%0d exp=100 words=1024",
                     {done, error, core_reset}, words_loaded);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_len_error();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        idle_rx();
        vectors++;
        if ({done, error, core_reset, bus.RX_READY} !== 4'b0110) begin
            miscompares++;
            $display("FAIL len_error got done/err/core_rst/ready=%b exp=0110",
                     {done, error, core_reset, bus.RX_READY});
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (words_loaded !== '0 || error !== 1'b1) begin
            miscompares++;
            $display("FAIL len_error_hold got words=%0d err=%b exp 0 1", words_loaded, error);
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({AW'(0), 32'h04030201});
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.RX_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_ready got=%b exp=0", bus.RX_READY);
        end
        @(negedge clk);
        vectors++;
        if ({bus.ADDR_W, bus.Q_W, bus.ENABLE_W, words_loaded} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got addr=%0h q=%08h en=%b words=%0d exp all 0",
                     bus.ADDR_W, bus.Q_W, bus.ENABLE_W, words_loaded);
        end
        vectors++;
        if ({done, error, core_reset} !== 3'b001 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_status got done/err/core_rst=%b pending=%0d exp=001 pending=0",
                     {done, error, core_reset}, exp_q.size());
        end
        rst = 1'b0;
        send_frame(one_word, 0, 1'b0);
        wait_final();
        vectors++;
        if ({done, error, core_reset} !== 3'b100 || words_loaded !== 11'd1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reload_after_reset got done/err/core_rst=%b words=%0d pending=%0d exp=100 1 0",
                     {done, error, core_reset}, words_loaded, exp_q.size());
        end
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_frame(one_word, 0, 1'b1);
        wait_final();
        vectors++;
        if ({done, error, core_reset} !== 3'b011 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bad_checksum got done/err/core_rst=%b pending=%0d exp=011 pending=0",
                     {done, error, core_reset}, exp_q.size());
        end
        vectors++;
        if (words_loaded !== 11'd1) begin
            miscompares++;
            $display("FAIL bad_checksum_words got=%0d exp=1", words_loaded);
        end
        pulse_start();
        send_frame(no_words, 0, 1'b1);
        wait_final();
        vectors++;
        if ({done, error, core_reset} !== 3'b011) begin
            miscompares++;
            $display("FAIL zero_len_bad_ck got done/err/core_rst=%b exp=011", {done, error, core_reset});
        end
    endtask
`endif

    initial begin
        basic_words = '{32'h0000_0013, 32'h0010_0093};
        one_word    = '{32'h4433_2211};
        no_words    = {};
        test_reset();
        test_basic_frame();
        test_reload_zero();
        test_gaps();
        test_full_image();
        test_len_error();
        test_reset_mid_frame();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time instruction-memory loader that sits directly upstream of the single-cycle core's instruction/data memory write port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words to consecutive memory addresses from 0, holding the core in reset until the image is complete.
- Replaces file-based preloading so a program can be delivered at run time (e.g. from a UART receiver).

Parameters:
- ADDR_WIDTH, 10, word-address width of the target memory.
- DATA_WIDTH, 32, memory word width; fixed at 32; any other value is a configuration error.

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  one-cycle rearm pulse; honoured only in DONE or ERR.
- RX_DATA  input  8  incoming byte.
- RX_VALID  input  1  RX_DATA valid.
- RX_READY  output  1  loader can accept a byte; a byte transfers when RX_VALID && RX_READY.
- ADDR_W  output  ADDR_WIDTH  memory write address.
- Q_W  output  DATA_WIDTH  memory write data.
- ENABLE_W  output  1  one-cycle write strobe.
- CORE_RESET  output  1  holds the core in reset while loading.
- DONE  output  1  image loaded successfully.
- ERROR  output  1  image rejected.
- WORDS_LOADED  output  ADDR_WIDTH+1  number of words written so far.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes with each word little-endian (first byte goes to Q_W[7:0]).
- FSM states: LEN_LO, LEN_HI, DATA, CHECK (present only with the optional feature), DONE, ERR.
- Reset (RESET high at a clock edge):
  - State goes to LEN_LO.
  - ADDR_W=0, Q_W=0, ENABLE_W=0, DONE=0, ERROR=0, WORDS_LOADED=0, CORE_RESET=1.
  - RX_READY is forced to 0 while RESET is high.
- RX_READY = 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERR. It is decoded from state, not registered.
- LEN_HI transition, on accepting the high length byte:
  - N > 2^ADDR_WIDTH -> ERR.
  - N == 0 -> DONE (or CHECK if the feature is enabled).
  - Otherwise -> DATA.
- DATA:
  - A 2-bit byte counter shifts bytes into a word register.
  - On acceptance of the 4th byte, the next cycle drives Q_W = assembled word and ENABLE_W = 1 for exactly one cycle.
  - ADDR_W = index of that word, i.e. the first word goes to address 0.
  - ADDR_W and WORDS_LOADED increment in the cycle after the strobe.
  - Byte acceptance continues uninterrupted during the strobe cycle; the loader has no back-pressure bubble.
- After the N-th word's strobe the FSM moves to DONE (or CHECK). ADDR_W never wraps because N is bounded by the LEN_HI check.
- Gaps in RX_VALID are allowed between any bytes; no state or counter changes while no byte is transferred.
- DONE:
  - DONE=1 and CORE_RESET drops to 0 in the same cycle as DONE rises.
  - All further RX bytes are refused.
- ERR: ERROR=1, CORE_RESET stays 1.
- START in DONE or ERR:
  - Next cycle: state LEN_LO; DONE, ERROR, ADDR_W and WORDS_LOADED cleared; CORE_RESET=1.
  - START in any other state is ignored.
- RESET mid-frame aborts the frame immediately. No pending strobe is issued and partial bytes are discarded.
- RESET and START in the same cycle: RESET wins.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte (or the header when N==0), state CHECK accepts one byte.
  - Expected value = XOR of all 4*N data bytes (0x00 when N==0).
  - Match -> DONE; mismatch -> ERR.
  - Words are already written to memory regardless; ERR keeps the core in reset.
- Not defined: CHECK state and XOR accumulator are absent; transitions go straight to DONE.

Decomposition:
- Shared package program_loader_pkg holds:
  - typedef enum for the FSM states;
  - localparam BYTES_PER_WORD = 4;
  - localparam LEN_BYTES = 2.
- One natural sub-module: byte_assembler. It covers the 2-bit byte counter, shift register and word_valid pulse, with inputs byte/valid/clear and outputs word/word_valid.
- FSM, address counter and checksum stay in the top module.

Test Plan:
- Reset then frame 02 00 | 13 00 00 00 | 93 00 10 00:
  - ENABLE_W pulses twice: ADDR_W=0 with Q_W=0x00000013, then ADDR_W=1 with Q_W=0x00100093.
  - Then DONE=1, CORE_RESET=0, WORDS_LOADED=2.
- Same frame with RX_VALID low for 3 cycles between every byte -> identical writes; no extra strobes; no state change during gaps.
- Header 01 08 (N=0x0801 > 1024) -> ERROR=1 after LEN_HI, no ENABLE_W, CORE_RESET=1.
- Reload and N==0:
  - After DONE, pulse START, send 00 00 -> DONE again with WORDS_LOADED=0.
  - With PROGRAM_LOADER_CHECKSUM_EN, the frame needs trailing 00; sending 01 instead -> ERROR=1.
- RESET asserted after 6 data bytes of a 2-word frame:
  - Only word 0 was written; outputs return to reset values and RX_READY=0 during reset.
  - A fresh frame then loads from address 0.
- Checksum build, frame 01 00 | 11 22 33 44 | 44 -> DONE=1.
- Same frame with trailing 45 -> ERROR=1 while word 0x44332211 is still written at address 0.
